mdu_sequencer: RTL



---
 rtl/mdu_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle controller for the M-extension datapath.
// Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU op per handshake,
// iterates a shift-add multiplier or restoring divider over 32 cycles and
// holds the registered result until the execute stage takes it.
// Handshake: a request is taken on a rising edge where req_valid && req_ready
// && !flush; a result is taken on a rising edge where resp_valid && resp_ready
// && !flush. flush always wins and returns the block to IDLE.
// Optional build macro: MDU_FAST_MUL_EN selects a single-cycle multiplier.
module mdu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_sel,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam logic [3:0] ALU_MUL    = 4'd0;
    localparam logic [3:0] ALU_MULH   = 4'd1;
    localparam logic [3:0] ALU_MULHSU = 4'd2;
    localparam logic [3:0] ALU_MULHU  = 4'd3;
    localparam logic [3:0] ALU_DIV    = 4'd4;
    localparam logic [3:0] ALU_DIVU   = 4'd5;
    localparam logic [3:0] ALU_REM    = 4'd6;
    localparam logic [3:0] ALU_REMU   = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [3:0]  sel_q, sel_d;
    // Multiply: {partial high, multiplier shifting out}. Divide: {remainder, quotient/dividend}.
    logic [63:0] acc_q, acc_d;
    logic [31:0] b_q, b_d;
    logic        neg_q, neg_d;     // product / quotient sign
    logic        rneg_q, rneg_d;   // remainder sign (op1 sign)
    logic [31:0] result_q, result_d;

    // Request decode, only meaningful on the accept cycle.
    logic        is_mul, is_div, sgn1, sgn2, neg1, neg2, div_zero, div_ovf;
    logic [31:0] abs1, abs2;

    assign is_mul   = (req_sel[3:2] == 2'b00);
    assign is_div   = (req_sel[3:2] == 2'b01);
    assign sgn1     = (req_sel == ALU_MUL) || (req_sel == ALU_MULH) || (req_sel == ALU_MULHSU) ||
                      (req_sel == ALU_DIV) || (req_sel == ALU_REM);
    assign sgn2     = (req_sel == ALU_MUL) || (req_sel == ALU_MULH) ||
                      (req_sel == ALU_DIV) || (req_sel == ALU_REM);
    assign neg1     = sgn1 & req_op1[31];
    assign neg2     = sgn2 & req_op2[31];
    assign abs1     = neg1 ? (32'd0 - req_op1) : req_op1;
    assign abs2     = neg2 ? (32'd0 - req_op2) : req_op2;
    assign div_zero = is_div && (req_op2 == 32'd0);
    assign div_ovf  = ((req_sel == ALU_DIV) || (req_sel == ALU_REM)) &&
                      (req_op1 == 32'h8000_0000) && (req_op2 == 32'hFFFF_FFFF);

    // Restoring divide step: shift in the next dividend bit, subtract if it fits.
    logic [32:0] trial, diff;
    logic [31:0] rem_n, quo_n, quo_fix, rem_fix, div_res;

    assign trial   = {acc_q[63:32], acc_q[31]};
    assign diff    = trial - {1'b0, b_q};
    assign rem_n   = diff[32] ? trial[31:0] : diff[31:0];
    assign quo_n   = {acc_q[30:0], ~diff[32]};
    assign quo_fix = neg_q  ? (32'd0 - quo_n) : quo_n;
    assign rem_fix = rneg_q ? (32'd0 - rem_n) : rem_n;
    assign div_res = sel_q[1] ? rem_fix : quo_fix;

    logic [31:0] mul_res;

`ifdef MDU_FAST_MUL_EN
    // Sign-extended operands; extension bit follows the op's signedness.
    logic [32:0] fa_q, fa_d, fb_q, fb_d;
    logic [63:0] fprod;

    assign fprod   = {{31{fa_q[32]}}, fa_q} * {{31{fb_q[32]}}, fb_q};
    assign mul_res = (sel_q == ALU_MUL) ? fprod[31:0] : fprod[63:32];
`else
    // Shift-add step: add multiplicand into the high half when the low bit is set.
    logic [32:0] sum;
    logic [63:0] mul_n, mul_fix;

    assign sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    assign mul_n   = {sum, acc_q[31:1]};
    assign mul_fix = neg_q ? (64'd0 - mul_n) : mul_n;
    assign mul_res = (sel_q == ALU_MUL) ? mul_fix[31:0] : mul_fix[63:32];
`endif

    assign req_ready   = (state_q == S_IDLE) && !reset;
    assign resp_valid  = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign resp_result = result_q;
    assign dbg_state   = state_q;

    // Next-state and datapath update for the sequencer.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sel_d    = sel_q;
        acc_d    = acc_q;
        b_d      = b_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
`ifdef MDU_FAST_MUL_EN
        fa_d     = fa_q;
        fb_d     = fb_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready && !flush) begin
                    sel_d   = req_sel;
                    acc_d   = {32'd0, abs1};
                    b_d     = abs2;
                    neg_d   = neg1 ^ neg2;
                    rneg_d  = neg1;
                    count_d = 5'd0;
`ifdef MDU_FAST_MUL_EN
                    fa_d    = {neg1, req_op1};
                    fb_d    = {neg2, req_op2};
`endif
                    if (is_mul) begin
                        state_d = S_MUL;
                    end else if (div_zero) begin
                        result_d = req_sel[1] ? req_op1 : 32'hFFFF_FFFF;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = req_sel[1] ? 32'd0 : 32'h8000_0000;
                        state_d  = S_DONE;
                    end else if (is_div) begin
                        state_d = S_DIV;
                    end else begin
                        result_d = 32'd0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_MUL: begin
`ifdef MDU_FAST_MUL_EN
                result_d = mul_res;
                state_d  = S_DONE;
`else
                acc_d   = mul_n;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    result_d = mul_res;
                    state_d  = S_DONE;
                end
`endif
            end
            S_DIV: begin
                acc_d   = {rem_n, quo_n};
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    result_d = div_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= 5'd0;
            sel_q    <= 4'd0;
            acc_q    <= 64'd0;
            b_q      <= 32'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= 32'd0;
`ifdef MDU_FAST_MUL_EN
            fa_q     <= 33'd0;
            fb_q     <= 33'd0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sel_q    <= sel_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
`ifdef MDU_FAST_MUL_EN
            fa_q     <= fa_d;
            fb_q     <= fb_d;
`endif
        end
    end

endmodule
